alu_ctrl_seq: RTL

- Producer side of the ALU interface: decodes RV32I instruction fields into op_mux_ctrl/cin for the combinational ALU.
- Also sequences the iterative RV32M subset: MUL, DIVU and REMU.
- Sits between instruction decode and the ALU. Decoded controls are registered; M-ops hold the core via a ready/valid handshake until the result is returned.

---
 rtl/alu_ctrl_seq_if.sv | 37 +++
 rtl/alu_ctrl_seq.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_ctrl_seq_if
// Brief    : Decode-to-ALU-control bundle: instruction fields in, ALU controls
//            and multiply/divide results out.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_ctrl_seq_if #(
    parameter int WORD_LENGTH = 32
);
    logic                   in_valid;
    logic                   in_ready;
    logic [6:0]             opcode;
    logic [2:0]             funct3;
    logic [6:0]             funct7;
    logic [WORD_LENGTH-1:0] rs1_val;
    logic [WORD_LENGTH-1:0] rs2_val;
    logic [3:0]             op_mux_ctrl;
    logic                   cin;
    logic                   ctrl_valid;
    logic                   illegal;
    logic                   md_valid;
    logic [WORD_LENGTH-1:0] md_result;

    // Upstream decode stage
    modport master (
        output in_valid, opcode, funct3, funct7, rs1_val, rs2_val,
        input  in_ready, op_mux_ctrl, cin, ctrl_valid, illegal, md_valid, md_result
    );

    // Control sequencer
    modport slave (
        input  in_valid, opcode, funct3, funct7, rs1_val, rs2_val,
        output in_ready, op_mux_ctrl, cin, ctrl_valid, illegal, md_valid, md_result
    );
endinterface
`default_nettype wire

// File: rtl/alu_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_ctrl_seq
// Brief    : RV32I ALU-control decoder with an iterative MUL/DIVU/REMU sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module alu_ctrl_seq #(
    parameter int WORD_LENGTH = 32,
    parameter int MD_CYCLES   = 32
) (
    input wire            clk,
    input wire            reset,
    alu_ctrl_seq_if.slave bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SLL  = 4'd1;
    localparam logic [3:0] ALU_SLT  = 4'd2;
    localparam logic [3:0] ALU_SLTU = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SRL  = 4'd5;
    localparam logic [3:0] ALU_SRA  = 4'd6;
    localparam logic [3:0] ALU_OR   = 4'd7;
    localparam logic [3:0] ALU_AND  = 4'd8;

    localparam logic [1:0] K_ILL = 2'd0;
    localparam logic [1:0] K_ALU = 2'd1;
    localparam logic [1:0] K_MD  = 2'd2;

    localparam logic [1:0] MD_MUL  = 2'd0;
    localparam logic [1:0] MD_DIVU = 2'd1;
    localparam logic [1:0] MD_REMU = 2'd2;

    localparam logic [5:0] CNT_LAST = 6'(MD_CYCLES - 1);

    logic [1:0]             state_q, state_d;
    logic [3:0]             op_mux_ctrl_q, op_mux_ctrl_d;
    logic                   cin_q, cin_d;
    logic                   ctrl_valid_q, ctrl_valid_d;
    logic                   illegal_q, illegal_d;
    logic                   md_valid_q, md_valid_d;
    logic [WORD_LENGTH-1:0] md_result_q, md_result_d;
    logic [1:0]             md_op_q, md_op_d;
    logic [5:0]             cnt_q, cnt_d;
    logic [WORD_LENGTH-1:0] opa_q, opa_d;
    logic [WORD_LENGTH-1:0] opb_q, opb_d;
    logic [WORD_LENGTH-1:0] acc_q, acc_d;

    logic                   w_in_ready;
    logic                   w_accept;
    logic [3:0]             w_base_code;
    logic [1:0]             w_dec_kind;
    logic [3:0]             w_dec_code;
    logic                   w_dec_cin;
    logic [1:0]             w_dec_md;
    logic                   w_div_zero;
    logic [WORD_LENGTH-1:0] w_mul_acc;
    logic [WORD_LENGTH:0]   w_rem_sh;
    logic [WORD_LENGTH:0]   w_rem_diff;
    logic                   w_rem_ge;

    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_div_zero = (w_dec_md != MD_MUL) && (bus.rs2_val == '0);

    // funct3 -> ALU code shared by register and immediate forms
    always_comb begin
        w_base_code = ALU_ADD;
        case (bus.funct3)
            3'b000:  w_base_code = ALU_ADD;
            3'b001:  w_base_code = ALU_SLL;
            3'b010:  w_base_code = ALU_SLT;
            3'b011:  w_base_code = ALU_SLTU;
            3'b100:  w_base_code = ALU_XOR;
            3'b101:  w_base_code = bus.funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  w_base_code = ALU_OR;
            default: w_base_code = ALU_AND;
        endcase
    end

    always_comb begin
        w_dec_kind = K_ILL;
        w_dec_code = ALU_ADD;
        w_dec_cin  = 1'b0;
        w_dec_md   = MD_MUL;
        case (bus.opcode)
            OPC_OP: begin
                if (bus.funct7 == F7_MULDIV) begin
                    case (bus.funct3)
                        3'b000:  begin w_dec_kind = K_MD; w_dec_md = MD_MUL;  end
                        3'b101:  begin w_dec_kind = K_MD; w_dec_md = MD_DIVU; end
                        3'b111:  begin w_dec_kind = K_MD; w_dec_md = MD_REMU; end
                        default: w_dec_kind = K_ILL;
                    endcase
                end else if ((bus.funct7 == F7_BASE) ||
                             ((bus.funct7 == F7_ALT) &&
                              ((bus.funct3 == 3'b000) || (bus.funct3 == 3'b101)))) begin
                    w_dec_kind = K_ALU;
                    w_dec_code = w_base_code;
                    w_dec_cin  = bus.funct7[5] && (bus.funct3 == 3'b000);
                end
            end
            OPC_OPIMM: begin
                // funct7 is immediate data except on the shift encodings
                w_dec_code = w_base_code;
                case (bus.funct3)
                    3'b001: begin
                        if (bus.funct7 == F7_BASE) w_dec_kind = K_ALU;
                    end
                    3'b101: begin
                        if ((bus.funct7 == F7_BASE) || (bus.funct7 == F7_ALT)) w_dec_kind = K_ALU;
                    end
                    default: w_dec_kind = K_ALU;
                endcase
            end
            OPC_LOAD, OPC_STORE, OPC_JALR, OPC_AUIPC, OPC_LUI, OPC_JAL: begin
                w_dec_kind = K_ALU;
            end
            OPC_BRANCH: begin
                case (bus.funct3)
                    3'b000, 3'b001: begin w_dec_kind = K_ALU; w_dec_cin = 1'b1; end
                    3'b100, 3'b101: begin w_dec_kind = K_ALU; w_dec_code = ALU_SLT;  end
                    3'b110, 3'b111: begin w_dec_kind = K_ALU; w_dec_code = ALU_SLTU; end
                    default:        w_dec_kind = K_ILL;
                endcase
            end
            default: w_dec_kind = K_ILL;
        endcase
    end

    // One step of shift-add multiply and restoring divide
    assign w_mul_acc  = acc_q + (opb_q[0] ? opa_q : '0);
    assign w_rem_sh   = {acc_q, opa_q[WORD_LENGTH-1]};
    assign w_rem_diff = w_rem_sh - {1'b0, opb_q};
    assign w_rem_ge   = ~w_rem_diff[WORD_LENGTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept && (w_dec_kind == K_MD)) begin
                    state_d = w_div_zero ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q == CNT_LAST) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready = (state_q == S_IDLE);
    end

    always_comb begin
        op_mux_ctrl_d = op_mux_ctrl_q;
        cin_d         = cin_q;
        ctrl_valid_d  = 1'b0;
        illegal_d     = 1'b0;
        md_valid_d    = 1'b0;
        md_result_d   = md_result_q;
        md_op_d       = md_op_q;
        cnt_d         = cnt_q;
        opa_d         = opa_q;
        opb_d         = opb_q;
        acc_d         = acc_q;

        if (w_accept) begin
            case (w_dec_kind)
                K_ALU: begin
                    op_mux_ctrl_d = w_dec_code;
                    cin_d         = w_dec_cin;
                    ctrl_valid_d  = 1'b1;
                end
                K_MD: begin
                    md_op_d = w_dec_md;
                    cnt_d   = '0;
                    opa_d   = bus.rs1_val;
                    opb_d   = bus.rs2_val;
                    acc_d   = '0;
                    // Divide by zero: preload the architectural results directly
                    if (w_div_zero) begin
                        opa_d = '1;
                        acc_d = bus.rs1_val;
                    end
                end
                default: illegal_d = 1'b1;
            endcase
        end

        if (state_q == S_BUSY) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 6'd1;
            if (md_op_q == MD_MUL) begin
                acc_d = w_mul_acc;
                opa_d = opa_q << 1;
                opb_d = opb_q >> 1;
            end else begin
                opa_d = {opa_q[WORD_LENGTH-2:0], w_rem_ge};
                acc_d = w_rem_ge ? w_rem_diff[WORD_LENGTH-1:0] : w_rem_sh[WORD_LENGTH-1:0];
            end
        end

        if (state_q == S_DONE) begin
            md_valid_d  = 1'b1;
            md_result_d = (md_op_q == MD_DIVU) ? opa_q : acc_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_mux_ctrl_q <= '0;
            cin_q         <= 1'b0;
            ctrl_valid_q  <= 1'b0;
            illegal_q     <= 1'b0;
            md_valid_q    <= 1'b0;
            md_result_q   <= '0;
            md_op_q       <= MD_MUL;
            cnt_q         <= '0;
            opa_q         <= '0;
            opb_q         <= '0;
            acc_q         <= '0;
        end else begin
            op_mux_ctrl_q <= op_mux_ctrl_d;
            cin_q         <= cin_d;
            ctrl_valid_q  <= ctrl_valid_d;
            illegal_q     <= illegal_d;
            md_valid_q    <= md_valid_d;
            md_result_q   <= md_result_d;
            md_op_q       <= md_op_d;
            cnt_q         <= cnt_d;
            opa_q         <= opa_d;
            opb_q         <= opb_d;
            acc_q         <= acc_d;
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.op_mux_ctrl = op_mux_ctrl_q;
    assign bus.cin         = cin_q;
    assign bus.ctrl_valid  = ctrl_valid_q;
    assign bus.illegal     = illegal_q;
    assign bus.md_valid    = md_valid_q;
    assign bus.md_result   = md_result_q;

endmodule
`default_nettype wire
